// File: rtl/clint_regfile.sv
// CLINT register back-end: mtime, per-hart mtimecmp/msip, RTC tick synchroniser,
// and per-hart timer/software interrupt outputs behind a RAM-like access port.
module clint_regfile #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned NR_CORES       = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [AXI_ADDR_WIDTH-1:0] address_i,
    input  logic                      en_i,
    input  logic                      we_i,
    input  logic [AXI_DATA_WIDTH-1:0] data_i,
    output logic [AXI_DATA_WIDTH-1:0] data_o,
    input  logic                      rtc_i,
    output logic [NR_CORES-1:0]       timer_irq_o,
    output logic [NR_CORES-1:0]       ipi_o
);

    logic [63:0]         mtime_q, mtime_d;
    logic [63:0]         mtimecmp_q [NR_CORES];
    logic [63:0]         mtimecmp_d [NR_CORES];
    logic [NR_CORES-1:0] msip_q, msip_d;
    logic [NR_CORES-1:0] timer_irq_q;
    logic [1:0]          rtc_sync_q;
    logic                rtc_prev_q;
    logic                tick;

    logic [12:0]         word;
    logic [1:0]          region;
    logic [10:0]         hart;
    logic                sel_mtime;
    logic [NR_CORES-1:0] sel_msip, sel_cmp;
    logic                wr, rd;
    logic                unused_addr;

    // Only offset bits [15:3] take part in decoding.
    assign word        = address_i[15:3];
    assign region      = word[12:11];
    assign hart        = word[10:0];
    assign sel_mtime   = (word == 13'h17FF);
    assign wr          = en_i & we_i;
    assign rd          = en_i & ~we_i;
    assign unused_addr = ^{address_i[AXI_ADDR_WIDTH-1:16], address_i[2:0]};

    always_comb begin
        sel_msip = '0;
        sel_cmp  = '0;
        for (int unsigned i = 0; i < NR_CORES; i++) begin
            sel_msip[i] = (region == 2'b00) && (hart == 11'(i));
            sel_cmp[i]  = (region == 2'b01) && (hart == 11'(i));
        end
    end

    assign tick = rtc_sync_q[1] & ~rtc_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rtc_sync_q <= '0;
            rtc_prev_q <= 1'b0;
        end else begin
            rtc_sync_q <= {rtc_sync_q[0], rtc_i};
            rtc_prev_q <= rtc_sync_q[1];
        end
    end

    // A software write to MTIME wins over a coincident tick.
    always_comb begin
        mtime_d = mtime_q;
        if (wr && sel_mtime) begin
            mtime_d = data_i;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        for (int unsigned i = 0; i < NR_CORES; i++) begin
            if (wr && sel_msip[i]) begin
                msip_d[i] = data_i[0];
            end
            if (wr && sel_cmp[i]) begin
                mtimecmp_d[i] = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q     <= '0;
            msip_q      <= '0;
            timer_irq_q <= '0;
            for (int unsigned i = 0; i < NR_CORES; i++) begin
                mtimecmp_q[i] <= '1;
            end
        end else begin
            mtime_q <= mtime_d;
            msip_q  <= msip_d;
            for (int unsigned i = 0; i < NR_CORES; i++) begin
                mtimecmp_q[i]  <= mtimecmp_d[i];
                timer_irq_q[i] <= (mtime_q >= mtimecmp_q[i]);
            end
        end
    end

    always_comb begin
        data_o = '0;
        if (rd) begin
            if (sel_mtime) begin
                data_o = mtime_q;
            end
            for (int unsigned i = 0; i < NR_CORES; i++) begin
                if (sel_msip[i]) begin
                    data_o = AXI_DATA_WIDTH'(msip_q[i]);
                end
                if (sel_cmp[i]) begin
                    data_o = mtimecmp_q[i];
                end
            end
        end
    end

    assign timer_irq_o = timer_irq_q;
    assign ipi_o       = msip_q;

endmodule

// File: tb/tb_clint_regfile.sv
// Directed self-checking bench for clint_regfile with two harts.
module tb_clint_regfile;

    logic        clk_i;
    logic        rst_ni;
    logic [63:0] address_i;
    logic        en_i;
    logic        we_i;
    logic [63:0] data_i;
    logic [63:0] data_o;
    logic        rtc_i;
    logic [1:0]  timer_irq_o;
    logic [1:0]  ipi_o;

    int checks = 0;
    int errors = 0;

    clint_regfile #(
        .AXI_ADDR_WIDTH(64),
        .AXI_DATA_WIDTH(64),
        .NR_CORES(2)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .address_i(address_i),
        .en_i(en_i),
        .we_i(we_i),
        .data_i(data_i),
        .data_o(data_o),
        .rtc_i(rtc_i),
        .timer_irq_o(timer_irq_o),
        .ipi_o(ipi_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] exp;
        logic [1:0]  ipi;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [63:0] addr, input logic [63:0] data);
        @(negedge clk_i);
        address_i = addr; data_i = data; en_i = 1'b1; we_i = 1'b1;
        @(posedge clk_i);
        #1;
        en_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic rd(input logic [63:0] addr, output logic [63:0] val);
        @(negedge clk_i);
        address_i = addr; en_i = 1'b1; we_i = 1'b0;
        #2;
        val = data_o;
        en_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    logic [63:0] v;
    logic [63:0] mt, prev_mt;
    int          t_mt5, t_irq;

    initial begin
        address_i = '0; en_i = 1'b0; we_i = 1'b0; data_i = '0; rtc_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("rst_irq", 64'(timer_irq_o), 64'd0);
        chk("rst_ipi", 64'(ipi_o), 64'd0);
        chk("rst_data", data_o, 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // we, addr, wdata, expected data_o, expected ipi_o after the edge
        tbl.push_back('{1'b0, 64'hBFF8, 64'h0, 64'h0, 2'b00, "rd_mtime_rst"});
        tbl.push_back('{1'b0, 64'h4000, 64'h0, '1,    2'b00, "rd_cmp0_rst"});
        tbl.push_back('{1'b0, 64'h4008, 64'h0, '1,    2'b00, "rd_cmp1_rst"});
        tbl.push_back('{1'b0, 64'h0000, 64'h0, 64'h0, 2'b00, "rd_msip0_rst"});
        tbl.push_back('{1'b1, 64'h0008, '1,    64'h0, 2'b10, "wr_msip1_ones"});
        tbl.push_back('{1'b0, 64'h0008, 64'h0, 64'h1, 2'b10, "rd_msip1"});
        tbl.push_back('{1'b0, 64'h0000, 64'h0, 64'h0, 2'b10, "rd_msip0"});
        tbl.push_back('{1'b0, 64'h8000, 64'h0, 64'h0, 2'b10, "rd_8000"});
        tbl.push_back('{1'b0, 64'h4010, 64'h0, 64'h0, 2'b10, "rd_cmp2"});
        tbl.push_back('{1'b1, 64'h8000, 64'hDEAD, 64'h0, 2'b10, "wr_8000"});
        tbl.push_back('{1'b0, 64'h8000, 64'h0, 64'h0, 2'b10, "rd_8000_after"});
        tbl.push_back('{1'b0, 64'hBFF8, 64'h0, 64'h0, 2'b10, "rd_mtime_after"});
        tbl.push_back('{1'b0, 64'h4000, 64'h0, '1,    2'b10, "rd_cmp0_after"});
        tbl.push_back('{1'b1, 64'h4008, 64'h1234_5678_9ABC_DEF0, 64'h0, 2'b10, "wr_cmp1"});
        tbl.push_back('{1'b0, 64'h400F, 64'h0, 64'h1234_5678_9ABC_DEF0, 2'b10, "rd_cmp1_lowbits"});
        tbl.push_back('{1'b1, 64'h0008, 64'h0, 64'h0, 2'b00, "wr_msip1_zero"});
        tbl.push_back('{1'b0, 64'h0008, 64'h0, 64'h0, 2'b00, "rd_msip1_zero"});
        tbl.push_back('{1'b1, 64'h0000, 64'h3, 64'h0, 2'b01, "wr_msip0_3"});
        tbl.push_back('{1'b0, 64'h0000, 64'h0, 64'h1, 2'b01, "rd_msip0_1"});
        tbl.push_back('{1'b1, 64'h0000, 64'h0, 64'h0, 2'b00, "wr_msip0_0"});
        tbl.push_back('{1'b0, 64'h0010, 64'h0, 64'h0, 2'b00, "rd_msip2"});

        foreach (tbl[k]) begin
            @(negedge clk_i);
            address_i = tbl[k].addr; data_i = tbl[k].data; we_i = tbl[k].we; en_i = 1'b1;
            #2;
            chk({tbl[k].name, "_data"}, data_o, tbl[k].exp);
            @(posedge clk_i);
            #1;
            chk({tbl[k].name, "_ipi"}, 64'(ipi_o), 64'(tbl[k].ipi));
            chk({tbl[k].name, "_irq"}, 64'(timer_irq_o), 64'd0);
        end
        en_i = 1'b0; we_i = 1'b0;

        // rtc held high for 20 cycles yields a single tick
        @(negedge clk_i);
        rtc_i = 1'b1;
        repeat (20) @(negedge clk_i);
        rtc_i = 1'b0;
        repeat (5) @(negedge clk_i);
        rd(64'hBFF8, v);
        chk("rtc_hold_once", v, 64'd1);

        // asynchronous reset in the middle of a write
        wr(64'hBFF8, 64'h55);
        wr(64'h0000, 64'h1);
        @(negedge clk_i);
        address_i = 64'hBFF8; en_i = 1'b0;
        #1;
        chk("en_low_data", data_o, 64'd0);
        chk("pre_rst_ipi", 64'(ipi_o), 64'b01);
        @(negedge clk_i);
        address_i = 64'h4000; data_i = 64'h0; en_i = 1'b1; we_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_ipi", 64'(ipi_o), 64'd0);
        chk("midrst_irq", 64'(timer_irq_o), 64'd0);
        @(negedge clk_i);
        en_i = 1'b0; we_i = 1'b0;
        rst_ni = 1'b1;
        rd(64'hBFF8, v);
        chk("midrst_mtime", v, 64'd0);
        rd(64'h4000, v);
        chk("midrst_cmp0", v, '1);

        // timer interrupt latency and deassertion
        wr(64'h4000, 64'd5);
        @(negedge clk_i);
        address_i = 64'hBFF8; en_i = 1'b1; we_i = 1'b0;
        prev_mt = '0; t_mt5 = -1; t_irq = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            rtc_i = (c < 30) && ((c % 6) < 3);
            @(posedge clk_i);
            #1;
            mt = data_o;
            if (mt == 64'd5 && t_mt5 < 0) t_mt5 = c;
            if (timer_irq_o[0] && t_irq < 0) t_irq = c;
            if (c > 0) chk("irq_vs_mtime", 64'(timer_irq_o[0]), 64'(prev_mt >= 64'd5));
            prev_mt = mt;
        end
        chk("timer_mtime5", mt, 64'd5);
        chk("irq_latency", 64'(t_irq - t_mt5), 64'd1);
        chk("irq1_quiet", 64'(timer_irq_o[1]), 64'd0);
        @(negedge clk_i);
        address_i = 64'h4000; data_i = 64'd100; en_i = 1'b1; we_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("irq_hold_1", 64'(timer_irq_o[0]), 64'd1);
        @(negedge clk_i);
        en_i = 1'b0; we_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("irq_drop_2", 64'(timer_irq_o[0]), 64'd0);

        // mtime wraps to zero
        wr(64'hBFF8, '1);
        @(negedge clk_i);
        rtc_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rtc_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rd(64'hBFF8, v);
        chk("mtime_wrap", v, 64'd0);

        // software write coinciding with a tick wins
        @(negedge clk_i);
        rtc_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        address_i = 64'hBFF8; data_i = 64'h10; en_i = 1'b1; we_i = 1'b1;
        @(posedge clk_i);
        #1;
        en_i = 1'b0; we_i = 1'b0;
        @(negedge clk_i);
        rtc_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rd(64'hBFF8, v);
        chk("wr_beats_tick", v, 64'h10);

        // 1000 rtc pulses at random phases
        do_reset();
        for (int p = 0; p < 1000; p++) begin
            @(negedge clk_i);
            #($urandom_range(1, 4));
            rtc_i = 1'b1;
            repeat ($urandom_range(3, 4)) @(negedge clk_i);
            #($urandom_range(1, 4));
            rtc_i = 1'b0;
            repeat ($urandom_range(3, 4)) @(negedge clk_i);
        end
        repeat (6) @(negedge clk_i);
        rd(64'hBFF8, v);
        chk("rtc_1000", v, 64'd1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
